// File: rtl/de_reg_pkg.sv
// Shared pipeline definitions for the D->E register: NOP encoding, Tnew width,
// instruction field positions and the E-stage register layout.
package de_reg_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned TNEW_W = 2;

  localparam logic [DATA_W-1:0] NOP = 32'h0000_0000;

  localparam int unsigned RS_HI = 25, RS_LO = 21;
  localparam int unsigned RT_HI = 20, RT_LO = 16;
  localparam int unsigned OP_HI = 31, OP_LO = 26;
  localparam int unsigned FUNC_HI = 5, FUNC_LO = 0;

  typedef struct packed {
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] pc8;
    logic [DATA_W-1:0] rs;
    logic [DATA_W-1:0] rt;
    logic [DATA_W-1:0] ext;
    logic [TNEW_W-1:0] tnew;
    logic              valid;
  } e_stage_t;

  function automatic logic [4:0] ir_rs(input logic [DATA_W-1:0] ir);
    return ir[RS_HI:RS_LO];
  endfunction

  function automatic logic [4:0] ir_rt(input logic [DATA_W-1:0] ir);
    return ir[RT_HI:RT_LO];
  endfunction

  function automatic logic [5:0] ir_op(input logic [DATA_W-1:0] ir);
    return ir[OP_HI:OP_LO];
  endfunction

  function automatic logic [5:0] ir_func(input logic [DATA_W-1:0] ir);
    return ir[FUNC_HI:FUNC_LO];
  endfunction

endpackage

// File: rtl/de_reg_if.sv
// D-stage inputs and E-stage outputs of the D->E pipeline register.
// master drives the decode side, slave is the register itself.
interface de_reg_if;
  import de_reg_pkg::*;

  logic              E_clr;
  logic [DATA_W-1:0] IR_D, PC_D, PC8_D, RD1_D, RD2_D, EXT_D;
  logic [TNEW_W-1:0] Tnew_D;
  logic [DATA_W-1:0] IR_E, PC_E, PC8_E, RS_E, RT_E, EXT_E;
  logic [TNEW_W-1:0] Tnew_E;
  logic              valid_E;

  modport master (
    output E_clr, IR_D, PC_D, PC8_D, RD1_D, RD2_D, EXT_D, Tnew_D,
    input  IR_E, PC_E, PC8_E, RS_E, RT_E, EXT_E, Tnew_E, valid_E
  );

  modport slave (
    input  E_clr, IR_D, PC_D, PC8_D, RD1_D, RD2_D, EXT_D, Tnew_D,
    output IR_E, PC_E, PC8_E, RS_E, RT_E, EXT_E, Tnew_E, valid_E
  );
endinterface

// File: rtl/de_reg_sat_counter.sv
// Saturating up-counter with asynchronous active-high reset; holds at all-ones.
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count <= '0;
    else if (inc && (count != {WIDTH{1'b1}}))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/de_reg.sv
// D->E pipeline register with bubble insertion and Tnew decrement.
// Optional bubble counter enabled by defining DE_BUBBLE_CNT_EN.
module de_reg
  import de_reg_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  de_reg_if.slave           de
`ifdef DE_BUBBLE_CNT_EN
  ,
  output logic [DATA_W-1:0] bubble_cnt
`endif
);

  e_stage_t e_p1;

  // One cycle spent in D: the result is one cycle closer when it reaches E.
  function automatic logic [TNEW_W-1:0] tnew_dec(input logic [TNEW_W-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

  // D -> E stage boundary
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_p1 <= '0;
    end else if (de.E_clr) begin
      e_p1       <= '0;
      e_p1.ir    <= NOP;
    end else begin
      e_p1.ir    <= de.IR_D;
      e_p1.pc    <= de.PC_D;
      e_p1.pc8   <= de.PC8_D;
      e_p1.rs    <= de.RD1_D;
      e_p1.rt    <= de.RD2_D;
      e_p1.ext   <= de.EXT_D;
      e_p1.tnew  <= tnew_dec(de.Tnew_D);
      e_p1.valid <= 1'b1;
    end
  end

  assign de.IR_E    = e_p1.ir;
  assign de.PC_E    = e_p1.pc;
  assign de.PC8_E   = e_p1.pc8;
  assign de.RS_E    = e_p1.rs;
  assign de.RT_E    = e_p1.rt;
  assign de.EXT_E   = e_p1.ext;
  assign de.Tnew_E  = e_p1.tnew;
  assign de.valid_E = e_p1.valid;

`ifdef DE_BUBBLE_CNT_EN
  sat_counter #(.WIDTH(DATA_W)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (de.E_clr),
    .count (bubble_cnt)
  );
`endif

endmodule

// File: tb/tb_de_reg.sv
// Bench for de_reg: random traffic plus directed pass-through, bubble, Tnew,
// async reset and priority scenarios against a behavioural model.
module tb_de_reg;
  import de_reg_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  de_reg_if bus ();

`ifdef DE_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt;
  de_reg dut (.clk(clk), .reset(reset), .de(bus.slave), .bubble_cnt(bubble_cnt));
`else
  de_reg dut (.clk(clk), .reset(reset), .de(bus.slave));
`endif

  always #5 clk = ~clk;

  logic [31:0] x_ir, x_pc, x_pc8, x_rs, x_rt, x_ext, x_tnew, x_valid;
  logic [31:0] x_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".IR_E"},    bus.IR_E,             x_ir);
    chk({tag, ".PC_E"},    bus.PC_E,             x_pc);
    chk({tag, ".PC8_E"},   bus.PC8_E,            x_pc8);
    chk({tag, ".RS_E"},    bus.RS_E,             x_rs);
    chk({tag, ".RT_E"},    bus.RT_E,             x_rt);
    chk({tag, ".EXT_E"},   bus.EXT_E,            x_ext);
    chk({tag, ".Tnew_E"},  32'(bus.Tnew_E),      x_tnew);
    chk({tag, ".valid_E"}, 32'(bus.valid_E),     x_valid);
`ifdef DE_BUBBLE_CNT_EN
    chk({tag, ".bubble_cnt"}, bubble_cnt, x_cnt);
`endif
  endtask

  task automatic clear_model();
    x_ir = 0; x_pc = 0; x_pc8 = 0; x_rs = 0; x_rt = 0; x_ext = 0;
    x_tnew = 0; x_valid = 0;
  endtask

  // Model of one rising edge, evaluated from the inputs present before it.
  task automatic tick(input string tag);
    if (reset) begin
      clear_model();
      x_cnt = 0;
    end else if (bus.E_clr) begin
      clear_model();
      if (x_cnt != 32'hFFFF_FFFF) x_cnt = x_cnt + 1;
    end else begin
      x_ir  = bus.IR_D;  x_pc = bus.PC_D; x_pc8 = bus.PC8_D;
      x_rs  = bus.RD1_D; x_rt = bus.RD2_D; x_ext = bus.EXT_D;
      x_tnew  = (bus.Tnew_D > 0) ? 32'(bus.Tnew_D) - 1 : 0;
      x_valid = 1;
    end
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic drive(input logic clr, input logic [31:0] ir, input logic [31:0] pc,
                       input logic [1:0] tn);
    bus.E_clr = clr; bus.IR_D = ir; bus.PC_D = pc; bus.PC8_D = pc + 8;
    bus.RD1_D = ir ^ 32'h1111_1111; bus.RD2_D = pc ^ 32'h2222_2222;
    bus.EXT_D = {16'h0, ir[15:0]}; bus.Tnew_D = tn;
  endtask

  initial begin
    drive(1'b0, 32'h0, 32'h0, 2'd0);
    clear_model();
    x_cnt = 0;
    #1;
    check_outputs("reset_state");

    // Reset held over an edge with live inputs still yields zeros.
    drive(1'b0, 32'hDEAD_BEEF, 32'h0000_4000, 2'd3);
    tick("reset_held");
    reset = 1'b0;

    // REQ-024 pass-through
    drive(1'b0, 32'h8C28_0004, 32'h0000_3000, 2'd3);
    tick("pass_lw");
    chk("pass_lw.pc8_literal", bus.PC8_E, 32'h0000_3008);
    chk("pass_lw.tnew_literal", 32'(bus.Tnew_E), 32'd2);

    // REQ-025 bubble then capture of the held dependent instruction
    drive(1'b1, 32'h0028_2020, 32'h0000_3004, 2'd1);
    tick("bubble");
    chk("bubble.ir_nop", bus.IR_E, NOP);
    drive(1'b0, 32'h0028_2020, 32'h0000_3004, 2'd1);
    tick("after_bubble");

    // REQ-026 Tnew sweep
    for (int t = 0; t < 4; t++) begin
      drive(1'b0, 32'h0100_0000 + t, 32'h0000_3100 + 4 * t, 2'(t));
      tick($sformatf("tnew_sweep%0d", t));
    end

    // REQ-029 clear beats non-zero D inputs, including back-to-back
    drive(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 2'd3);
    tick("clr_vs_data0");
    tick("clr_vs_data1");
    tick("clr_vs_data2");

    // REQ-027 asynchronous reset between edges
    drive(1'b0, 32'h0085_2020, 32'h0000_3200, 2'd2);
    tick("load_addu");
    #3;
    reset = 1'b1;
    #1;
    clear_model();
    x_cnt = 0;
    check_outputs("async_reset");
    // REQ-029 reset and clear together
    drive(1'b1, 32'h1234_5678, 32'h0000_3300, 2'd3);
    tick("reset_and_clr");
    #2;
    reset = 1'b0;
    drive(1'b0, 32'h2408_0005, 32'h0000_3400, 2'd2);
    tick("first_after_reset");

    // Randomised traffic
    for (int i = 0; i < 60; i++) begin
      bus.E_clr  = ($urandom_range(0, 3) == 0);
      bus.IR_D   = $urandom(); bus.PC_D  = $urandom(); bus.PC8_D = $urandom();
      bus.RD1_D  = $urandom(); bus.RD2_D = $urandom(); bus.EXT_D = $urandom();
      bus.Tnew_D = 2'($urandom_range(0, 3));
      tick($sformatf("rand%0d", i));
    end

`ifdef DE_BUBBLE_CNT_EN
    // Fresh count: 5 bubbles with 3 back-to-back, then saturation
    reset = 1'b1;
    #1;
    reset = 1'b0;
    clear_model();
    x_cnt = 0;
    check_outputs("cnt_reset");
    drive(1'b1, 32'h0, 32'h0, 2'd0); tick("cnt_b1");
    drive(1'b0, 32'h1, 32'h4, 2'd1); tick("cnt_gap1");
    drive(1'b1, 32'h0, 32'h0, 2'd0); tick("cnt_b2");
    tick("cnt_b3");
    tick("cnt_b4");
    drive(1'b0, 32'h2, 32'h8, 2'd1); tick("cnt_gap2");
    drive(1'b1, 32'h0, 32'h0, 2'd0); tick("cnt_b5");
    chk("cnt_five", bubble_cnt, 32'd5);
    drive(1'b0, 32'h3, 32'hC, 2'd1);
    force dut.u_cnt.count = 32'hFFFF_FFFE;
    #1;
    release dut.u_cnt.count;
    x_cnt = 32'hFFFF_FFFE;
    drive(1'b1, 32'h0, 32'h0, 2'd0);
    tick("cnt_sat1");
    tick("cnt_sat2");
    tick("cnt_sat3");
    chk("cnt_saturated", bubble_cnt, 32'hFFFF_FFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
